// File: rtl/msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..ROUNDS-1], one word per advance.
// Optional macro MSGSCHED_WK_SUM_EN adds the K ROM and drives wk_out = W[t]+K[t]; otherwise wk_out is 0.
module msg_schedule #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         advance,
    output logic [31:0]  w_out,
    output logic [31:0]  wk_out,
    output logic [5:0]   round,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WIN_N  = 16;
    localparam int unsigned RND_W  = 6;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

`ifdef MSGSCHED_WK_SUM_EN
    localparam logic [WORD_W-1:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  win_q [WIN_N];
    logic [WORD_W-1:0]  win_d [WIN_N];
    logic [WORD_W-1:0]  w_out_q, w_out_d;
    logic [WORD_W-1:0]  wk_out_q, wk_out_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               w_valid_q, w_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WORD_W-1:0]  next_w;

    // Window holds W[t..t+15]; this is W[t+16].
    assign next_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d   = state_q;
        w_out_d   = w_out_q;
        round_d   = round_q;
        w_valid_d = w_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        for (int i = 0; i < WIN_N; i++) begin
            win_d[i] = win_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    for (int i = 0; i < WIN_N; i++) begin
                        win_d[i] = block_in[(WIN_N-1-i)*WORD_W +: WORD_W];
                    end
                    w_out_d   = block_in[511:480];
                    round_d   = '0;
                    w_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    for (int i = 0; i < WIN_N-1; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[WIN_N-1] = next_w;
                    if (round_q == LAST_ROUND) begin
                        state_d   = ST_DONE;
                        w_out_d   = '0;
                        round_d   = '0;
                        w_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        w_out_d = win_q[1];
                        round_d = round_q + RND_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                w_out_d   = '0;
                round_d   = '0;
                w_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase

        // wk follows whatever word/round is about to be registered.
`ifdef MSGSCHED_WK_SUM_EN
        wk_out_d = w_valid_d ? (w_out_d + K_TAB[round_d]) : '0;
`else
        wk_out_d = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            w_out_q   <= '0;
            wk_out_q  <= '0;
            round_q   <= '0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            w_out_q   <= w_out_d;
            wk_out_q  <= wk_out_d;
            round_q   <= round_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign w_out   = w_out_q;
    assign wk_out  = wk_out_q;
    assign round   = round_q;
    assign w_valid = w_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
